ps2_host_tx: RTL

PS/2 host-to-device transmitter. It is the outbound counterpart of the receive-only mouse and keyboard controllers that feed the chimp game. It sends one command byte to a PS/2 device using the host-request protocol, for example 0xF4 to enable mouse data reporting or 0xFF to reset the device. It sits between game/init logic and the open-drain PS/2 pads, and shares the pads with the existing receivers.

---
 rtl/chimp_pkg.sv | 22 ++
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/chimp_pkg.sv
// Shared chimp PS/2 definitions: host-transmit state encoding, command and ACK bytes.
package chimp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        WAITIDLE,
        DONE,
        ERR
    } ps2TxStateT;

    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE   = 8'hFA;

    function automatic logic oddParity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 pad plus a falling-edge detector on the synchronized level.
module ps2_sync_edge (
    input  logic clk,
    input  logic iReset,
    input  logic iLine,
    output logic oLevel,
    output logic oFall
);

    logic metaQ, syncQ, prevQ;

    // Reset to the idle-high level so releasing reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (iReset) begin
            metaQ <= 1'b1;
            syncQ <= 1'b1;
            prevQ <= 1'b1;
        end else begin
            metaQ <= iLine;
            syncQ <= metaQ;
            prevQ <= syncQ;
        end
    end

    assign oLevel = syncQ;
    assign oFall  = prevQ & ~syncQ;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data pads.
// Define PS2_TX_AUTO_INIT_EN to send PS2_CMD_ENABLE once after every reset.
module ps2_host_tx
    import chimp_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       iPs2Clk,
    input  logic       iPs2Dat,
    output logic       oPs2ClkLow,
    output logic       oPs2DatLow,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int unsigned TimeoutMax = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT
                                                                        : XFER_TIMEOUT;
    localparam int unsigned CntMax = (TimeoutMax > INHIBIT_CYCLES) ? TimeoutMax : INHIBIT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    ps2TxStateT      stateQ, stateD;
    logic [CntW-1:0] cntQ, cntD;
    logic [3:0]      bitCntQ, bitCntD;
    logic [7:0]      dataQ, dataD;
    logic            parityQ, parityD;
    logic            txBitQ, txBitD;
    logic            sendGo;
    logic [7:0]      sendByte;

    logic clkLevel, clkFall, datLevel, datFallUnused;

    ps2_sync_edge uSyncClk (
        .clk    (clk),
        .iReset (iReset),
        .iLine  (iPs2Clk),
        .oLevel (clkLevel),
        .oFall  (clkFall)
    );

    ps2_sync_edge uSyncDat (
        .clk    (clk),
        .iReset (iReset),
        .iLine  (iPs2Dat),
        .oLevel (datLevel),
        .oFall  (datFallUnused)
    );

`ifdef PS2_TX_AUTO_INIT_EN
    logic autoPendQ, autoPendD;

    always_ff @(posedge clk) begin
        if (iReset) autoPendQ <= 1'b1;
        else        autoPendQ <= autoPendD;
    end

    // The pending auto send masks iSend until it has been accepted.
    always_comb begin
        autoPendD = autoPendQ;
        sendGo    = autoPendQ | iSend;
        sendByte  = autoPendQ ? PS2_CMD_ENABLE : iData;
        if (stateQ == IDLE) autoPendD = 1'b0;
    end
`else
    assign sendGo   = iSend;
    assign sendByte = iData;
`endif

    always_ff @(posedge clk) begin
        if (iReset) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            bitCntQ <= '0;
            dataQ   <= '0;
            parityQ <= 1'b0;
            txBitQ  <= 1'b1;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            bitCntQ <= bitCntD;
            dataQ   <= dataD;
            parityQ <= parityD;
            txBitQ  <= txBitD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        cntD       = (&cntQ) ? cntQ : cntQ + CntW'(1);
        bitCntD    = bitCntQ;
        dataD      = dataQ;
        parityD    = parityQ;
        txBitD     = txBitQ;
        oPs2ClkLow = 1'b0;
        oPs2DatLow = 1'b0;
        oDone      = 1'b0;
        oError     = 1'b0;
        oBusy      = (stateQ != IDLE);

        unique case (stateQ)
            IDLE: begin
                cntD    = '0;
                bitCntD = '0;
                txBitD  = 1'b1;
                if (sendGo) begin
                    dataD   = sendByte;
                    parityD = oddParity(sendByte);
                    stateD  = INHIBIT;
                end
            end
            INHIBIT: begin
                oPs2ClkLow = 1'b1;
                if (cntQ == CntW'(INHIBIT_CYCLES - 1)) begin
                    oPs2DatLow = 1'b1;
                    cntD       = '0;
                    stateD     = REQ;
                end
            end
            REQ: begin
                oPs2DatLow = 1'b1;
                if (clkFall) begin
                    txBitD  = dataQ[0];
                    bitCntD = 4'd1;
                    cntD    = '0;
                    stateD  = XFER;
                end else if (cntQ == CntW'(START_TIMEOUT - 1)) begin
                    stateD = ERR;
                end
            end
            XFER: begin
                oPs2DatLow = ~txBitQ;
                if (cntQ == CntW'(XFER_TIMEOUT - 1)) begin
                    stateD = ERR;
                end else if (clkFall) begin
                    bitCntD = bitCntQ + 4'd1;
                    if (bitCntQ <= 4'd7)       txBitD = dataQ[bitCntQ[2:0]];
                    else if (bitCntQ == 4'd8)  txBitD = parityQ;
                    else if (bitCntQ == 4'd9)  txBitD = 1'b1;
                    else                       stateD = datLevel ? ERR : WAITIDLE;
                end
            end
            WAITIDLE: begin
                if (cntQ == CntW'(XFER_TIMEOUT - 1)) stateD = ERR;
                else if (clkLevel && datLevel)      stateD = DONE;
            end
            DONE: begin
                oDone  = 1'b1;
                stateD = IDLE;
            end
            ERR: begin
                oError = 1'b1;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

endmodule
